// File: rtl/led_mon_pkg.sv
// Shared types and helpers for the LED flow monitor: FSM encoding,
// one-hot rotation and an 8-bit saturating increment.
package led_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2
  } led_mon_state_e;

  // Rotate the low 'width' bits of p by one position, with wrap-around.
  // dir=0 steps toward the MSB, dir=1 toward the LSB.
  function automatic logic [31:0] rot_next(input logic [31:0] p,
                                           input int unsigned width,
                                           input logic dir);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    if (!dir) r = (p << 1) | (p >> (width - 1));
    else      r = (p >> 1) | (p << (width - 1));
    return r & mask;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/led_dwell_timer.sv
// Counts cycles since the last LED change and flags a held period that is
// shorter or longer than the DWELL +/- TOL window.
module led_dwell_timer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DWELL = 8,
  parameter int unsigned TOL   = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  output logic too_short_o,
  output logic too_long_o
);

  // Held period is cnt_q+1, so the window bounds shift down by one.
  localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(DWELL - TOL - 1);
  localparam logic [CNT_W-1:0] LONG_LIM  = CNT_W'(DWELL + TOL);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)          cnt_d = '0;
    else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign too_short_o = (cnt_q < SHORT_LIM);
  assign too_long_o  = (cnt_q >= LONG_LIM);

endmodule

// File: rtl/led_flow_monitor.sv
// Observer for a walking one-hot LED bus: locks onto the pattern, then checks
// every step's order and dwell; sticky flags plus step/error counters.
module led_flow_monitor
  import led_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DWELL = 8,
  parameter int unsigned TOL   = 1,
  parameter bit          DIR   = 1'b0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] led_in,
  output logic             locked,
  output logic             err_pattern,
  output logic             err_timing,
  output logic             err_pulse,
  output logic [15:0]      step_count,
  output logic [7:0]       err_count,
  output led_mon_state_e   dbg_state
);

  logic [WIDTH-1:0] led_q, led_prev_q, exp_next;
  led_mon_state_e   state_q, state_d;
  logic             locked_q, locked_d;
  logic             err_pat_q, err_pat_d;
  logic             err_tim_q, err_tim_d;
  logic             pulse_q, pulse_d;
  logic [15:0]      step_q, step_d;
  logic [7:0]       errc_q, errc_d;
  logic             change, is_onehot, in_order, err_ev;
  logic             too_short, too_long, timer_clr;

  assign change    = (led_q != led_prev_q);
  assign is_onehot = $onehot(led_q);
  assign exp_next  = WIDTH'(rot_next(32'(led_prev_q), WIDTH, DIR));
  assign in_order  = (led_q == exp_next);
  assign timer_clr = change || (state_q == ST_IDLE && is_onehot);

  led_dwell_timer #(.CNT_W(CNT_W), .DWELL(DWELL), .TOL(TOL)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (timer_clr),
    .too_short_o(too_short),
    .too_long_o (too_long)
  );

  always_comb begin
    state_d   = state_q;
    err_pat_d = err_pat_q;
    err_tim_d = err_tim_q;
    step_d    = step_q;
    errc_d    = errc_q;
    pulse_d   = 1'b0;
    err_ev    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (is_onehot) state_d = ST_SYNC;
      ST_SYNC: begin
        // First dwell is of unknown length, so only order decides the lock.
        if (change) begin
          if (in_order) begin
            state_d = ST_TRACK;
            step_d  = step_q + 16'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_TRACK: begin
        if (change) begin
          if (!in_order)             err_pat_d = 1'b1;
          if (too_short || too_long) err_tim_d = 1'b1;
          if (!in_order || too_short || too_long) err_ev = 1'b1;
          else                                    step_d = step_q + 16'd1;
        end else if (too_long) begin
          err_tim_d = 1'b1;
          err_ev    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (err_ev) begin
      pulse_d = 1'b1;
      errc_d  = sat_inc8(errc_q);
      state_d = ST_IDLE;
    end
    locked_d = (state_d == ST_TRACK);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q      <= '0;
      led_prev_q <= '0;
      state_q    <= ST_IDLE;
      locked_q   <= 1'b0;
      err_pat_q  <= 1'b0;
      err_tim_q  <= 1'b0;
      pulse_q    <= 1'b0;
      step_q     <= '0;
      errc_q     <= '0;
    end else begin
      led_q      <= led_in;
      led_prev_q <= led_q;
      state_q    <= state_d;
      locked_q   <= locked_d;
      err_pat_q  <= err_pat_d;
      err_tim_q  <= err_tim_d;
      pulse_q    <= pulse_d;
      step_q     <= step_d;
      errc_q     <= errc_d;
    end
  end

  assign locked      = locked_q;
  assign err_pattern = err_pat_q;
  assign err_timing  = err_tim_q;
  assign err_pulse   = pulse_q;
  assign step_count  = step_q;
  assign err_count   = errc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_led_flow_monitor.sv
// Bench for led_flow_monitor: directed scenarios plus randomized LED flows,
// checked every cycle against a step-level reference model.
module tb_led_flow_monitor;
  import led_mon_pkg::*;

  localparam int       W     = 4;
  localparam int       DWELL = 8;
  localparam int       TOL   = 1;
  localparam bit       DIR   = 1'b0;
  localparam int       OW    = 28;

  // clock / reset
  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   led_in = '0;
  logic           locked, err_pattern, err_timing, err_pulse;
  logic [15:0]    step_count;
  logic [7:0]     err_count;
  led_mon_state_e dbg_state;

  always #5 clock = ~clock;

  led_flow_monitor #(.WIDTH(W), .DWELL(DWELL), .TOL(TOL), .DIR(DIR), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .led_in     (led_in),
    .locked     (locked),
    .err_pattern(err_pattern),
    .err_timing (err_timing),
    .err_pulse  (err_pulse),
    .step_count (step_count),
    .err_count  (err_count),
    .dbg_state  (dbg_state)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [OW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: tracks the bus one sample behind, judges each change
  localparam int M_IDLE = 0, M_SYNC = 1, M_TRACK = 2;
  int         m_mode, m_step, m_errc, held;
  logic [3:0] m_q, m_prev;
  logic       m_ep, m_et, m_pulse;

  function automatic logic [3:0] next_of(input logic [3:0] p);
    int x;
    x = int'(p);
    if (DIR == 1'b0) x = (x * 2) % 16 + x / 8;
    else             x = x / 2 + (x % 2) * 8;
    return 4'(x);
  endfunction

  task automatic model_edge(input logic rst, input logic [3:0] v);
    logic chg, bad_ord, bad_time, ev;
    if (rst) begin
      m_mode = M_IDLE; m_step = 0; m_errc = 0; held = 1;
      m_q = '0; m_prev = '0; m_ep = 0; m_et = 0; m_pulse = 0;
    end else begin
      chg      = (m_q != m_prev);
      bad_ord  = (m_q != next_of(m_prev));
      bad_time = (held < DWELL - TOL) || (held > DWELL + TOL);
      ev       = 1'b0;
      if (m_mode == M_IDLE) begin
        if ($countones(m_q) == 1) m_mode = M_SYNC;
      end else if (m_mode == M_SYNC) begin
        if (chg) begin
          if (!bad_ord) begin m_mode = M_TRACK; m_step = (m_step + 1) % 65536; end
          else m_mode = M_IDLE;
        end
      end else begin
        if (chg && (bad_ord || bad_time)) begin
          m_ep = m_ep | bad_ord;
          m_et = m_et | bad_time;
          ev = 1'b1;
        end else if (chg) begin
          m_step = (m_step + 1) % 65536;
        end else if (held > DWELL + TOL) begin
          m_et = 1'b1;
          ev = 1'b1;
        end
      end
      m_pulse = ev;
      if (ev) begin
        if (m_errc < 255) m_errc++;
        m_mode = M_IDLE;
      end
      held   = chg ? 1 : held + 1;
      m_prev = m_q;
      m_q    = v;
    end
    exp_q.push_back({m_mode == M_TRACK, m_ep, m_et, m_pulse, 16'(m_step), 8'(m_errc)});
  endtask

  // driver: one clock per call, outputs compared #1 after the edge
  task automatic cycle(input logic rst, input logic [3:0] v);
    logic [OW-1:0] e;
    @(negedge clock);
    reset  = rst;
    led_in = v;
    model_edge(rst, v);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("locked",      32'(locked),      32'(e[27]));
    chk("err_pattern", 32'(err_pattern), 32'(e[26]));
    chk("err_timing",  32'(err_timing),  32'(e[25]));
    chk("err_pulse",   32'(err_pulse),   32'(e[24]));
    chk("step_count",  32'(step_count),  32'(e[23:8]));
    chk("err_count",   32'(err_count),   32'(e[7:0]));
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, v);
  endtask

  initial begin
    logic [3:0] cur;
    logic [3:0] bad;
    int         dw;

    // 1: reset with toggling bus
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'($urandom_range(0, 15)));
    chk("t1_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("t1_errc",  32'(err_count), 32'd0);

    // 2: clean flow with wrap
    hold(4'b0001, 8);
    hold(4'b0010, 1);
    chk("t2_lock_n1", 32'(locked), 32'd0);
    hold(4'b0010, 1);
    chk("t2_lock_n2", 32'(locked), 32'd1);
    hold(4'b0010, 6);
    hold(4'b0100, 8);
    hold(4'b1000, 8);
    hold(4'b0001, 8);
    chk("t2_steps", 32'(step_count), 32'd4);
    chk("t2_errc",  32'(err_count),  32'd0);

    // 3: out-of-order step, then relock
    hold(4'b0010, 8);
    hold(4'b1000, 3);
    chk("t3_pat",  32'(err_pattern), 32'd1);
    chk("t3_errc", 32'(err_count),   32'd1);
    chk("t3_lock", 32'(locked),      32'd0);
    hold(4'b1000, 5);
    hold(4'b0001, 8);
    hold(4'b0010, 8);
    chk("t3_relock", 32'(locked),      32'd1);
    chk("t3_sticky", 32'(err_pattern), 32'd1);

    // 4: dwell window edges and stall
    hold(4'b0100, 7);
    hold(4'b1000, 9);
    hold(4'b0001, 6);
    hold(4'b0010, 3);
    chk("t4_tim",  32'(err_timing), 32'd1);
    chk("t4_errc", 32'(err_count),  32'd2);
    hold(4'b0010, 5);
    hold(4'b0100, 20);
    chk("t4_stall", 32'(err_count), 32'd3);
    hold(4'b1000, 8);

    // 5: bad patterns until the error counter saturates
    for (int i = 0; i < 300; i++) begin
      bad = (i % 2 == 0) ? 4'b0011 : 4'b0000;
      hold(4'b0001, 2);
      hold(4'b0010, 2);
      hold(bad, 2);
    end
    chk("t5_sat", 32'(err_count), 32'd255);

    // 6: reset pulse mid-track, then relock from scratch
    hold(4'b0001, 8);
    hold(4'b0010, 8);
    hold(4'b0100, 4);
    chk("t6_pre_lock", 32'(locked), 32'd1);
    cycle(1'b1, 4'b0100);
    chk("t6_rst_errc", 32'(err_count), 32'd0);
    hold(4'b1000, 8);
    hold(4'b0001, 3);
    chk("t6_step", 32'(step_count), 32'd1);
    chk("t6_lock", 32'(locked),     32'd1);

    // random flows with occasional glitches, bad dwells and resets
    cur = 4'b0001;
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 99) < 2) begin
        cycle(1'b1, cur);
      end
      if ($urandom_range(0, 9) == 0) cur = 4'($urandom_range(0, 15));
      else                           cur = next_of(cur);
      dw = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 14)
                                        : $urandom_range(DWELL - TOL, DWELL + TOL));
      hold(cur, dw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
